// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined MIPS control unit: opcodes, control-bundle
// bit positions, field widths and the all-zero NOP bundle.
package ctrl_pkg;

  localparam int OP_W     = 6;
  localparam int REG_AW   = 5;
  localparam int CNT_W    = 16;
  localparam int BUNDLE_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOP   = 6'b111111;

  localparam int B_ALUSRC    = 0;
  localparam int B_ALUOP_LSB = 1;
  localparam int B_ALUOP_MSB = 2;
  localparam int B_REGDST    = 3;
  localparam int B_MEMREAD   = 4;
  localparam int B_MEMWRITE  = 5;
  localparam int B_REGWRITE  = 6;
  localparam int B_MEMTOREG  = 7;

  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = '0;

  // Instructions whose rt field is a source operand, so it can collide with a load target.
  function automatic logic reads_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage instruction slot presented by the IF/ID register to the control unit.
interface pipe_ctrl_if
  import ctrl_pkg::*;
  ();

  // valid_i qualifies op/rs/rt; there is no ready: back-pressure is returned as stall_o,
  // and flush_i kills the slot in the same cycle regardless of valid_i.
  logic              valid_i;
  logic [OP_W-1:0]   op_i;
  logic [REG_AW-1:0] rs_i;
  logic [REG_AW-1:0] rt_i;
  logic              flush_i;

  modport master (output valid_i, op_i, rs_i, rt_i, flush_i);
  modport slave  (input  valid_i, op_i, rs_i, rt_i, flush_i);

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: 8-bit control bundle plus branch/jump/illegal flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     op_i,
  output logic [BUNDLE_W-1:0] bundle_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                illegal_o
);

  always_comb begin
    bundle_o  = NOP_BUNDLE;
    branch_o  = 1'b0;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        bundle_o[B_ALUOP_MSB:B_ALUOP_LSB] = ALUOP_RTYPE;
        bundle_o[B_REGDST]                = 1'b1;
        bundle_o[B_REGWRITE]              = 1'b1;
      end
      OP_ADDI: begin
        bundle_o[B_ALUSRC]   = 1'b1;
        bundle_o[B_REGWRITE] = 1'b1;
      end
      OP_LW: begin
        bundle_o[B_ALUSRC]   = 1'b1;
        bundle_o[B_MEMREAD]  = 1'b1;
        bundle_o[B_REGWRITE] = 1'b1;
        bundle_o[B_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        bundle_o[B_ALUSRC]   = 1'b1;
        bundle_o[B_MEMWRITE] = 1'b1;
      end
      OP_BEQ:  branch_o = 1'b1;
      OP_J:    jump_o   = 1'b1;
      OP_NOP:  ;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: ID decode, load-use stall, bubble insertion and the
// ID/EX, EX/MEM, MEM/WB control registers. Counters built with CTRL_PERF_CNT_EN.
module pipe_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_ctrl_if.slave        id,
  output logic              branch_o,
  output logic              jump_o,
  output logic              stall_o,
  output logic [3:0]        ex_ctrl_o,
  output logic [1:0]        mem_ctrl_o,
  output logic [1:0]        wb_ctrl_o,
  output logic              illegal_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  logic [BUNDLE_W-1:0] dec_bundle;
  logic                dec_branch;
  logic                dec_jump;
  logic                dec_illegal;

  ctrl_decode u_decode (
    .op_i      (id.op_i),
    .bundle_o  (dec_bundle),
    .branch_o  (dec_branch),
    .jump_o    (dec_jump),
    .illegal_o (dec_illegal)
  );

  logic [BUNDLE_W-1:0] idex_q, idex_d;
  logic [REG_AW-1:0]   idex_rt_q, idex_rt_d;
  logic                idex_ill_q, idex_ill_d;
  logic [3:0]          exmem_q;
  logic [1:0]          memwb_q;
  logic                hazard;
  logic                bubble;

  assign hazard = id.valid_i & idex_q[B_MEMREAD] & (idex_rt_q != '0)
                & ((idex_rt_q == id.rs_i) | ((idex_rt_q == id.rt_i) & reads_rt(id.op_i)));

  assign stall_o = hazard & ~id.flush_i;
  assign bubble  = ~id.valid_i | stall_o | id.flush_i;

  assign branch_o = dec_branch & id.valid_i & ~stall_o & ~id.flush_i;
  assign jump_o   = dec_jump   & id.valid_i & ~stall_o & ~id.flush_i;

  always_comb begin
    idex_d     = NOP_BUNDLE;
    idex_rt_d  = '0;
    idex_ill_d = 1'b0;
    if (!bubble) begin
      idex_d     = dec_bundle;
      idex_rt_d  = id.rt_i;
      idex_ill_d = dec_illegal;
    end
  end

  // The stall bubble clears ID/EX MemRead, which is what bounds a load-use stall to one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q     <= NOP_BUNDLE;
      idex_rt_q  <= '0;
      idex_ill_q <= 1'b0;
      exmem_q    <= '0;
      memwb_q    <= '0;
    end else begin
      idex_q     <= idex_d;
      idex_rt_q  <= idex_rt_d;
      idex_ill_q <= idex_ill_d;
      exmem_q    <= idex_q[B_MEMTOREG:B_MEMREAD];
      memwb_q    <= exmem_q[3:2];
    end
  end

  assign ex_ctrl_o  = idex_q[B_REGDST:B_ALUSRC];
  assign mem_ctrl_o = exmem_q[1:0];
  assign wb_ctrl_o  = memwb_q;
  assign illegal_o  = idex_ill_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (id.flush_i && id.valid_i && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
